// File: rtl/booth_multiplier_pkg.sv
// rtl/booth_multiplier_pkg.sv - shared constants and Booth recoding helper for booth_multiplier
//
// Purpose: FSM state encodings and the radix-2 Booth operation codes, plus the
//          decode of {Q[0], Q_-1} into an operation.
// Contents: S_IDLE/S_RUN/S_DONE, booth_op_t (BOOTH_NOP/ADD/SUB), booth_decode().
package booth_multiplier_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth: 01 ends a run of ones (add M), 10 starts one (subtract M).
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    booth_op_t op;
    case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_add33.sv
// rtl/booth_add33.sv - 33-bit add/subtract for the Booth accumulator
//
// Purpose: sum = a + b (sub=0) or a - b computed as a + ~b + 1 (sub=1).
//          Bits [31:0] use one rca32, bit 32 one extra fa. Purely combinational.
// Ports:   a, b [32:0] (in) - accumulator and sign-extended multiplicand
//          sub (in)         - 1 selects subtract
//          sum [32:0] (out) - result; the final carry-out is discarded
module booth_add33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  logic [32:0] b_eff;
  logic        carry_low;
  logic        carry_unused;

  // Subtract by inverting the operand and injecting the +1 through carry-in.
  assign b_eff = b ^ {33{sub}};

  rca32 u_rca (
    .a  (a[31:0]),
    .b  (b_eff[31:0]),
    .ci (sub),
    .s  (sum[31:0]),
    .co (carry_low)
  );

  // The 33-bit accumulator can never overflow, so the top carry is dropped.
  fa u_fa_top (
    .a  (a[32]),
    .b  (b_eff[32]),
    .ci (carry_low),
    .s  (sum[32]),
    .co (carry_unused)
  );

endmodule

// File: rtl/fa.sv
// rtl/fa.sv - one-bit full adder cell
//
// Purpose: the basic adder cell shared with the ALU datapath.
// Ports:   a, b, ci (in)  - addend bits and carry-in
//          s, co (out)    - sum and carry-out
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca32.sv
// rtl/rca32.sv - 32-bit ripple-carry adder built from fa cells
//
// Purpose: the ALU's 32-bit ripple-carry adder.
// Ports:   a, b [31:0] (in) - addends
//          ci (in)          - carry-in
//          s [31:0] (out)   - sum
//          co (out)         - carry-out of bit 31
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [32:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[32];

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - multi-cycle signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH
//
// Purpose: one Booth iteration per clock for WIDTH clocks; product to hi/lo.
// Ports:   clk, rst_n (in)        - clock, asynchronous active-low reset
//          start (in)             - request, sampled only in IDLE
//          mcand, mplier [W] (in) - signed operands, sampled with start
//          busy (out)             - high while iterating
//          done (out)             - one-cycle pulse, product valid
//          hi, lo [W] (out)       - product[2W-1:W], product[W-1:0]
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state, state_nxt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CNT_W-1:0] count;

  booth_op_t        op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             last;

  assign op = booth_decode(q_reg[0], q_m1);

  booth_add33 u_add (
    .a   (acc),
    .b   (m_reg),
    .sub (op == BOOTH_SUB),
    .sum (add_sum)
  );

  assign acc_step = (op == BOOTH_NOP) ? acc : add_sum;

  // Arithmetic shift of {A, Q, Q_-1}; the bit leaving Q becomes the new Q_-1.
  assign acc_sh = {acc_step[WIDTH], acc_step[WIDTH:1]};
  assign q_sh   = {acc_step[0], q_reg[WIDTH-1:1]};
  assign last   = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      m_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == S_IDLE && start) begin
      acc   <= '0;
      m_reg <= {mcand[WIDTH-1], mcand};
      q_reg <= mplier;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (state == S_RUN) begin
      acc   <= acc_sh;
      q_reg <= q_sh;
      q_m1  <= q_reg[0];
      count <= count + 1'b1;
      // hi/lo only move on the final iteration so they hold across later runs.
      if (last) begin
        hi <= acc_sh[WIDTH-1:0];
        lo <= q_sh;
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier
module tb_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  booth_multiplier dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] sm;
    logic signed [63:0] sq;
    sm = {{32{m[31]}}, m};
    sq = {{32{q[31]}}, q};
    return sm * sq;
  endfunction

  // Drives start for one edge (T0) and records the expected product.
  task automatic launch(input logic [31:0] m, input logic [31:0] q, input logic [63:0] expv);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    sb_q.push_back(expv);
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
  endtask

  // Observes one run from T0, sampling on negedges; i is the cycle index T<i>.
  task automatic wait_done(input int poke_at, input logic [31:0] pm, input logic [31:0] pq,
                           output int done_at, output int busy_n, output int busy_bad,
                           output int hold_bad, output logic [63:0] prod, output logic done_after);
    logic [63:0] prev;
    prev = {hi, lo};
    done_at = 0; busy_n = 0; busy_bad = 0; hold_bad = 0; prod = '0; done_after = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (poke_at != 0 && i == poke_at) begin
        start = 1'b1; mcand = pm; mplier = pq;
      end else if (poke_at != 0 && i == poke_at + 1) begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_n++;
      if (busy !== (i <= 32)) busy_bad++;
      if (i <= 32 && {hi, lo} !== prev) hold_bad++;
      if (done === 1'b1) begin
        done_at = i;
        prod = {hi, lo};
        @(negedge clk);
        done_after = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mcand = 32'h1234_5678; mplier = 32'h9abc_def0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_product got %h exp 0", {hi, lo}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, hi, lo} !== 66'h0) begin errors++; $display("FAIL reset_idle got %h exp 0", {busy, done, hi, lo}); end
  endtask

  task automatic test_basic();
    logic [31:0] ms[5] = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] qs[5] = '{32'd4, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [63:0] es[5] = '{64'h0000_0000_0000_000C, 64'hFFFF_FFFF_FFFF_FFDD,
                           64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001,
                           64'h3FFF_FFFF_0000_0001};
    int da, bn, bb, hb; logic [63:0] pr; logic dn; logic [63:0] ex;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      launch(ms[k], qs[k], es[k]);
      wait_done(0, 0, 0, da, bn, bb, hb, pr, dn);
      ex = sb_q.pop_front();
      checks++; if (pr !== ex) begin errors++; $display("FAIL basic%0d_product got %h exp %h", k, pr, ex); end
      checks++; if (da != 33) begin errors++; $display("FAIL basic%0d_done_cycle got %0d exp 33", k, da); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL basic%0d_done_width got %b exp 0", k, dn); end
      checks++; if (bb != 0 || bn != 32) begin errors++; $display("FAIL basic%0d_busy got %0d/%0d exp 32/0", k, bn, bb); end
      checks++; if (hb != 0) begin errors++; $display("FAIL basic%0d_hold got %0d exp 0", k, hb); end
    end
    // (-2^31) * 1 exercises the 33-bit accumulator on a single subtract.
    @(negedge clk);
    launch(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    wait_done(0, 0, 0, da, bn, bb, hb, pr, dn);
    ex = sb_q.pop_front();
    checks++; if (pr !== ex) begin errors++; $display("FAIL minint_x1 got %h exp %h", pr, ex); end
  endtask

  task automatic test_start_while_busy();
    int da, bn, bb, hb; logic [63:0] pr; logic dn; logic [63:0] ex;
    @(negedge clk);
    launch(32'd6, 32'd7, 64'd42);
    wait_done(10, 32'd9, 32'd9, da, bn, bb, hb, pr, dn);
    ex = sb_q.pop_front();
    checks++; if (pr !== ex) begin errors++; $display("FAIL busy_start_product got %h exp %h", pr, ex); end
    checks++; if (da != 33 || dn !== 1'b0) begin errors++; $display("FAIL busy_start_done got %0d/%b exp 33/0", da, dn); end
    checks++; if (bb != 0) begin errors++; $display("FAIL busy_start_busy got %0d exp 0", bb); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00 || {hi, lo} !== 64'd42) begin
        errors++; $display("FAIL busy_start_idle got %b %h exp 00 %h", {busy, done}, {hi, lo}, 64'd42);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int da, bn, bb, hb; logic [63:0] pr; logic dn; logic [63:0] ex;
    @(negedge clk);
    launch(32'd12345, 32'd6789, ref_mul(32'd12345, 32'd6789));
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_prebusy got %b exp 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      errors++; $display("FAIL abort_async got %h exp 0", {busy, done, hi, lo});
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_no_done got %b exp 00", {busy, done}); end
    end
    launch(32'd2, 32'd3, 64'd6);
    wait_done(0, 0, 0, da, bn, bb, hb, pr, dn);
    ex = sb_q.pop_front();
    checks++; if (pr !== ex || da != 33) begin errors++; $display("FAIL abort_rerun got %h@%0d exp %h@33", pr, da, ex); end
    checks++; if (dn !== 1'b0 || bb != 0) begin errors++; $display("FAIL abort_rerun_timing got %b/%0d exp 0/0", dn, bb); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ms[2] = '{32'd100, 32'd0};
    logic [31:0] qs[2] = '{32'hFFFF_FFFF, 32'h1234_5678};
    logic [63:0] es[2] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'h0};
    int da, bn, bb, hb; logic [63:0] pr; logic dn; logic [63:0] ex;
    @(negedge clk);
    // The second launch starts at the negedge where wait_done returned, so its start is seen at T34.
    for (int k = 0; k < 2; k++) begin
      launch(ms[k], qs[k], es[k]);
      wait_done(0, 0, 0, da, bn, bb, hb, pr, dn);
      ex = sb_q.pop_front();
      checks++; if (pr !== ex) begin errors++; $display("FAIL b2b%0d_product got %h exp %h", k, pr, ex); end
      checks++; if (da != 33 || dn !== 1'b0) begin errors++; $display("FAIL b2b%0d_timing got %0d/%b exp 33/0", k, da, dn); end
      checks++; if (bb != 0 || hb != 0) begin errors++; $display("FAIL b2b%0d_busy_hold got %0d/%0d exp 0/0", k, bb, hb); end
    end
  endtask

  task automatic test_random();
    int da, bn, bb, hb; logic [63:0] pr; logic dn; logic [63:0] ex;
    logic [31:0] m, q;
    @(negedge clk);
    for (int n = 0; n < 1500; n++) begin
      m = $urandom;
      q = $urandom;
      case ($urandom_range(0, 9))
        0: m = 32'h8000_0000;
        1: q = 32'h8000_0000;
        2: m = 32'h0;
        3: q = 32'hFFFF_FFFF;
        default: ;
      endcase
      launch(m, q, ref_mul(m, q));
      wait_done(0, 0, 0, da, bn, bb, hb, pr, dn);
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL rand_scoreboard got empty exp entry");
      end else begin
        ex = sb_q.pop_front();
        checks++;
        if (pr !== ex || da != 33 || dn !== 1'b0) begin
          errors++; $display("FAIL rand_%0d %h*%h got %h@%0d exp %h@33", n, m, q, pr, da, ex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
